// File: rtl/instruction_fetch_queue.sv
// Instruction fetch unit with an N-entry instruction queue between ICache and Decoder.
// Resolves jal/branch/jalr next-PC locally and flushes cleanly on RoB redirect.
module instruction_fetch_queue #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned IQ_DEPTH_LOG = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst,
  input  logic                  Sys_rdy,
  input  logic                  ICIF_en,
  input  logic [31:0]           ICIF_data,
  output logic                  IFIC_en,
  output logic [ADDR_WIDTH-1:0] IFIC_pc,
  input  logic                  DCIF_ask_IF,
  output logic                  IFDC_en,
  output logic [ADDR_WIDTH-1:0] IFDC_pc,
  output logic [6:0]            IFDC_opcode,
  output logic [24:0]           IFDC_remain_inst,
  output logic                  IFDC_predict_result,
  input  logic                  PDIF_en,
  input  logic                  PDIF_predict_result,
  output logic                  IFPD_predict_en,
  output logic [ADDR_WIDTH-1:0] IFPD_pc,
  output logic                  IFPD_feedback_en,
  output logic                  IFPD_branch_result,
  output logic [ADDR_WIDTH-1:0] IFPD_feedback_pc,
  input  logic                  RoBIF_flush,
  input  logic                  RoBIF_jalr_en,
  input  logic                  RoBIF_branch_en,
  input  logic                  RoBIF_branch_result,
  input  logic [ADDR_WIDTH-1:0] RoBIF_branch_pc,
  input  logic [ADDR_WIDTH-1:0] RoBIF_next_pc
);

  localparam int unsigned DEPTH = 1 << IQ_DEPTH_LOG;
  localparam int unsigned CW    = IQ_DEPTH_LOG + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {IDLE, WAIT_IC, WAIT_PD, WAIT_JALR} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           inst;
    logic                  pred;
  } entry_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   pc;
  logic [31:0]             inst_q;
  logic                    drop_pending;
  logic [IQ_DEPTH_LOG-1:0] head;
  logic [IQ_DEPTH_LOG-1:0] tail;
  logic [CW-1:0]           count;
  entry_t                  mem [DEPTH];

  logic                    push;
  logic                    pop;
  entry_t                  push_e;
  entry_t                  head_e;
  logic [6:0]              opcode;
  logic signed [31:0]      j_imm;
  logic signed [31:0]      b_imm;

  assign opcode = ICIF_data[6:0];
  assign j_imm  = {{12{ICIF_data[31]}}, ICIF_data[19:12], ICIF_data[20], ICIF_data[30:21], 1'b0};
  assign b_imm  = {{20{inst_q[31]}}, inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};

  // Head of queue is presented combinationally to the Decoder
  assign head_e              = mem[head];
  assign IFDC_en             = (count != '0);
  assign IFDC_pc             = head_e.pc;
  assign IFDC_opcode         = head_e.inst[6:0];
  assign IFDC_remain_inst    = head_e.inst[31:7];
  assign IFDC_predict_result = head_e.pred;

  // Push/pop decisions; a flush, reset or stall suppresses both
  always_comb begin
    push        = 1'b0;
    push_e.pc   = pc;
    push_e.inst = ICIF_data;
    push_e.pred = 1'b0;
    case (state)
      WAIT_IC: push = ICIF_en && !drop_pending && (opcode != OP_BRANCH);
      WAIT_PD: begin
        push        = PDIF_en;
        push_e.inst = inst_q;
        push_e.pred = PDIF_predict_result;
      end
      default: push = 1'b0;
    endcase
    pop = IFDC_en && DCIF_ask_IF;
    if (Sys_rst || !Sys_rdy || RoBIF_flush) begin
      push = 1'b0;
      pop  = 1'b0;
    end
  end

  always_ff @(posedge Sys_clk) begin
    if (push) mem[tail] <= push_e;
  end

  // Fetch FSM, queue pointers and predictor feedback
  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      state              <= IDLE;
      pc                 <= RESET_PC;
      inst_q             <= '0;
      drop_pending       <= 1'b0;
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      IFIC_en            <= 1'b0;
      IFIC_pc            <= RESET_PC;
      IFPD_predict_en    <= 1'b0;
      IFPD_pc            <= '0;
      IFPD_feedback_en   <= 1'b0;
      IFPD_branch_result <= 1'b0;
      IFPD_feedback_pc   <= '0;
    end else if (Sys_rdy) begin
      IFPD_predict_en  <= 1'b0;
      IFPD_feedback_en <= RoBIF_branch_en;
      if (RoBIF_branch_en) begin
        IFPD_branch_result <= RoBIF_branch_result;
        IFPD_feedback_pc   <= RoBIF_branch_pc;
      end

      if (RoBIF_flush) begin
        state        <= IDLE;
        pc           <= RoBIF_next_pc;
        head         <= '0;
        tail         <= '0;
        count        <= '0;
        IFIC_en      <= 1'b0;
        // The in-flight response, if not arriving now, must be swallowed later
        drop_pending <= (IFIC_en || drop_pending) && !ICIF_en;
      end else begin
        if (ICIF_en && drop_pending) drop_pending <= 1'b0;
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        count <= count + CW'(push) - CW'(pop);

        case (state)
          IDLE: begin
            if (count < FULL && !drop_pending) begin
              IFIC_en <= 1'b1;
              IFIC_pc <= pc;
              state   <= WAIT_IC;
            end
          end
          WAIT_IC: begin
            if (ICIF_en) begin
              IFIC_en <= 1'b0;
              case (opcode)
                OP_JAL: begin
                  pc    <= pc + ADDR_WIDTH'(j_imm);
                  state <= IDLE;
                end
                OP_BRANCH: begin
                  inst_q          <= ICIF_data;
                  IFPD_predict_en <= 1'b1;
                  IFPD_pc         <= pc;
                  state           <= WAIT_PD;
                end
                OP_JALR: state <= WAIT_JALR;
                default: begin
                  pc    <= pc + ADDR_WIDTH'(4);
                  state <= IDLE;
                end
              endcase
            end
          end
          WAIT_PD: begin
            if (PDIF_en) begin
              pc    <= PDIF_predict_result ? pc + ADDR_WIDTH'(b_imm) : pc + ADDR_WIDTH'(4);
              state <= IDLE;
            end
          end
          WAIT_JALR: begin
            if (RoBIF_jalr_en) begin
              pc    <= RoBIF_next_pc;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/instruction_fetch_queue.md
Name: instruction_fetch_queue

Overview:
- Parametrised successor to the single-slot instruction fetcher.
- Decouples ICache fetch from the Decoder with an N-entry instruction queue. Each entry holds {pc, inst[31:0], predict_result}.
- Keeps one outstanding ICache request, resolves jal/branch/jalr next-PC itself (predictor handshake, RoB jalr wait), and flushes cleanly on misprediction.
- Sits between ICache, Predictor, Decoder and RoB.

Parameters:
ADDR_WIDTH, 32, PC/address width
IQ_DEPTH_LOG, 2, log2 of queue depth (depth = 2**IQ_DEPTH_LOG, min 1)
RESET_PC, 0, PC loaded on reset

Ports:
Sys_clk  in  1  clock, rising edge
Sys_rst  in  1  synchronous active-high reset
Sys_rdy  in  1  global enable; when 0 all state holds
ICIF_en  in  1  ICache response valid (1-cycle pulse)
ICIF_data  in  32  fetched instruction
IFIC_en  out  1  ICache request, held until ICIF_en
IFIC_pc  out  ADDR_WIDTH  request address
DCIF_ask_IF  in  1  Decoder ready/pop
IFDC_en  out  1  queue head valid (= !empty)
IFDC_pc  out  ADDR_WIDTH  head pc
IFDC_opcode  out  7  head inst[6:0]
IFDC_remain_inst  out  25  head inst[31:7]
IFDC_predict_result  out  1  head prediction (0 for non-branch)
PDIF_en  in  1  prediction valid
PDIF_predict_result  in  1  1 = taken
IFPD_predict_en  out  1  prediction request pulse
IFPD_pc  out  ADDR_WIDTH  branch pc for prediction
IFPD_feedback_en  out  1  feedback pulse
IFPD_branch_result  out  1  registered RoB branch outcome
IFPD_feedback_pc  out  ADDR_WIDTH  registered RoB branch pc
RoBIF_flush  in  1  misprediction/redirect (active-high)
RoBIF_jalr_en  in  1  jalr target valid
RoBIF_branch_en  in  1  branch committed
RoBIF_branch_result  in  1  actual outcome
RoBIF_branch_pc  in  ADDR_WIDTH  branch pc
RoBIF_next_pc  in  ADDR_WIDTH  redirect / jalr target

Behaviour:
- Reset (Sys_rst=1 at edge):
  - pc=RESET_PC, state=IDLE, queue empty (head=tail=count=0), drop_pending=0.
  - IFIC_en=0, IFPD_predict_en=0, IFPD_feedback_en=0.
  - IFDC_en=0 because the queue is empty.
  - Reset overrides Sys_rdy. Reset mid-request discards the in-flight response.
- Sys_rdy=0: no state change. Outputs hold their registered values.
- States:
  - IDLE: if count<DEPTH and !flush -> assert IFIC_en with IFIC_pc=pc, go to WAIT_IC.
  - WAIT_IC: on ICIF_en (and !drop_pending), decode ICIF_data[6:0]:
    - jal 1101111: push {pc,inst,0}; pc+=J-imm; go to IDLE.
    - branch 1100011: latch inst; IFPD_predict_en=1 for exactly 1 cycle with IFPD_pc=pc; go to WAIT_PD.
    - jalr 1100111: push {pc,inst,0}; go to WAIT_JALR.
    - other: push; pc+=4; go to IDLE.
  - WAIT_PD: on PDIF_en, push {pc,inst,PDIF_predict_result}; pc = taken ? pc+B-imm : pc+4; go to IDLE.
  - WAIT_JALR: on RoBIF_jalr_en, pc=RoBIF_next_pc; go to IDLE.
- ICache request: IFIC_en drops the cycle after ICIF_en is seen. Earliest re-request is the following cycle, so throughput is 1 inst per 2 cycles minimum.
- Immediates are sign-extended to 32 bits. PC arithmetic is modulo 2**ADDR_WIDTH.
- Queue:
  - Head outputs are combinational from storage.
  - Pop when IFDC_en && DCIF_ask_IF.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap at DEPTH.
  - A request is only issued when count<DEPTH and at most one request is ever outstanding, so a push never overflows. Pop on empty is ignored.
- Flush (RoBIF_flush=1) has the highest priority over push, pop, PDIF_en and RoBIF_jalr_en:
  - pc=RoBIF_next_pc, queue cleared, state=IDLE, IFIC_en=0, IFPD_predict_en=0.
  - If a request is outstanding and ICIF_en is not asserted that cycle, set drop_pending. The next ICIF_en is discarded and clears drop_pending. No new request is issued while drop_pending=1.
  - An ICIF_en arriving in the flush cycle itself is discarded.
  - A late PDIF_en after a flush is ignored (state is no longer WAIT_PD).
- Feedback:
  - RoBIF_branch_en registers into IFPD_feedback_en as a 1-cycle pulse, latency 1.
  - IFPD_branch_result and IFPD_feedback_pc are registered alongside it.
  - Feedback is independent of flush and is still sent in a flush cycle.

Test Plan:
- Reset, then ICache returns addi (0x00100093) at pc 0 -> IFIC_pc=0; after response the queue holds {0,0x00100093,0}; next IFIC_pc=4; IFDC_en=1.
- jal x0,+16 (0x0100006F) at pc 8 -> entry pushed with pc 8; next IFIC_pc=0x18; IFPD_predict_en never asserted.
- beq +8 at pc 0x20 with PDIF_predict_result=1 -> IFPD_predict_en pulses 1 cycle with IFPD_pc=0x20; after PDIF_en, entry predict=1 and next IFIC_pc=0x28. Repeat with not-taken -> 0x24.
- DCIF_ask_IF=0 with depth 4 and only non-branch instructions -> exactly 4 entries are pushed, then IFIC_en stays 0. Assert DCIF_ask_IF -> pops in FIFO order with wrap-around, and fetching resumes.
- jalr at pc 0x40 -> stall in WAIT_JALR. RoBIF_jalr_en with next_pc 0x100 -> next IFIC_pc=0x100. Repeat with RoBIF_flush (next_pc 0x200) in the same cycle -> pc=0x200 and the queue is emptied.
- RoBIF_flush (next_pc 0x80) while a request is outstanding and the queue holds 3 entries -> IFDC_en=0 next cycle. The next ICIF_en is dropped (count stays 0), and the following request has IFIC_pc=0x80.
- RoBIF_branch_en=1, result=1, pc=0x30 -> next cycle IFPD_feedback_en=1, IFPD_feedback_pc=0x30; the cycle after that IFPD_feedback_en=0.
